// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter; widths update only at frame boundaries.
// Optional feature: define SERVO_SLEW_EN to rate-limit angle changes to SLEW_STEP per frame.
module servo_pwm_array #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned PERIOD_CYCLES = 1000000,
   parameter int unsigned MIN_PULSE     = 50000,
   parameter int unsigned MAX_PULSE     = 100000,
   parameter int unsigned ANGLE_W       = 8,
   parameter int unsigned MAX_ANGLE     = 180,
   parameter int unsigned SLEW_STEP     = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH*ANGLE_W-1:0]   angle_in,
   input  logic [NUM_CH-1:0]           angle_valid,
   input  logic [NUM_CH-1:0]           enable,
   output logic [NUM_CH-1:0]           pwm_out,
   output logic                        frame_tick,
   output logic [NUM_CH-1:0]           settled
);

   localparam int unsigned CNT_W  = $clog2(PERIOD_CYCLES);
   localparam int unsigned SPAN   = MAX_PULSE - MIN_PULSE;
   localparam int unsigned PROD_W = ANGLE_W + $clog2(SPAN + 1);

   localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   MIN_W     = CNT_W'(MIN_PULSE);
   localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(MAX_ANGLE);
   localparam logic [PROD_W-1:0]  SPAN_P    = PROD_W'(SPAN);
   localparam logic [PROD_W-1:0]  DIV_P     = PROD_W'(MAX_ANGLE);

`ifdef SERVO_SLEW_EN
   localparam int unsigned STEP_LIM = SLEW_STEP;
`else
   // A limit no smaller than MAX_ANGLE never binds, so current jumps straight to target.
   localparam int unsigned STEP_LIM = (SLEW_STEP > MAX_ANGLE) ? SLEW_STEP : MAX_ANGLE;
`endif
   localparam logic [ANGLE_W-1:0] STEP_A = ANGLE_W'(STEP_LIM);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             boundary;

   always_comb begin
      boundary = (cnt_q == LAST_CNT);
      cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
      tick_d   = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign frame_tick = tick_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [ANGLE_W-1:0] field;
      logic [ANGLE_W-1:0] tgt_q, tgt_d;
      logic [ANGLE_W-1:0] cur_q, cur_d;
      logic [ANGLE_W-1:0] nxt_cur;
      logic [ANGLE_W-1:0] diff;
      logic [PROD_W-1:0]  prod;
      logic [PROD_W-1:0]  quot;
      logic [CNT_W-1:0]   width_q, width_d;
      logic               en_q, en_d;
      logic               pwm_q, pwm_d;
      logic               settled_q, settled_d;

      always_comb begin
         field = angle_in[k*ANGLE_W +: ANGLE_W];
         tgt_d = tgt_q;
         if (angle_valid[k]) begin
            tgt_d = (field > ANGLE_MAX) ? ANGLE_MAX : field;
         end

         // Step uses the target held before this cycle, so a same-cycle load waits a frame.
         if (tgt_q >= cur_q) begin
            diff    = tgt_q - cur_q;
            nxt_cur = (32'(diff) > STEP_LIM) ? cur_q + STEP_A : tgt_q;
         end else begin
            diff    = cur_q - tgt_q;
            nxt_cur = (32'(diff) > STEP_LIM) ? cur_q - STEP_A : tgt_q;
         end

         prod = PROD_W'(nxt_cur) * SPAN_P;
         quot = prod / DIV_P;

         cur_d   = boundary ? nxt_cur : cur_q;
         width_d = boundary ? MIN_W + CNT_W'(quot) : width_q;
         en_d    = boundary ? enable[k] : en_q;

         pwm_d     = en_q && (cnt_q < width_q);
         settled_d = (cur_q == tgt_q);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tgt_q     <= '0;
            cur_q     <= '0;
            width_q   <= '0;
            en_q      <= 1'b0;
            pwm_q     <= 1'b0;
            settled_q <= 1'b1;
         end else begin
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            width_q   <= width_d;
            en_q      <= en_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
         end
      end

      assign pwm_out[k] = pwm_q;
      assign settled[k] = settled_q;
   end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: frame-level reference model, vector table, directed corner cases and random frames.
module tb_servo_pwm_array;

   localparam int unsigned NCH  = 2;
   localparam int unsigned PER  = 100;
   localparam int unsigned MINP = 10;
   localparam int unsigned MAXP = 20;
   localparam int unsigned MAXA = 180;
   localparam int unsigned AW   = 8;
   localparam int unsigned SLEW = 30;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NCH*AW-1:0]   angle_in;
   logic [NCH-1:0]      angle_valid;
   logic [NCH-1:0]      enable;
   logic [NCH-1:0]      pwm_out;
   logic                frame_tick;
   logic [NCH-1:0]      settled;

   always #5 clk = ~clk;

   servo_pwm_array #(
      .NUM_CH(NCH), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
      .ANGLE_W(AW), .MAX_ANGLE(MAXA), .SLEW_STEP(SLEW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .angle_in(angle_in), .angle_valid(angle_valid),
      .enable(enable), .pwm_out(pwm_out), .frame_tick(frame_tick), .settled(settled)
   );

   typedef struct {
      int         a0;
      int         a1;
      logic [1:0] vld;
      logic [1:0] en;
      int         x0;
      int         x1;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: target, current angle, latched width and enable per channel.
   int mtgt [NCH];
   int mcur [NCH];
   int mw   [NCH];
   bit men  [NCH];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int clampa(input int a);
      return (a > MAXA) ? MAXA : a;
   endfunction

   function automatic int wfor(input int a);
      return MINP + (a * (MAXP - MINP)) / MAXA;
   endfunction

   function automatic int stepc(input int c, input int t);
      int lim;
`ifdef SERVO_SLEW_EN
      lim = SLEW;
`else
      lim = 1 << 30;
`endif
      if (t - c > lim) return c + lim;
      if (c - t > lim) return c - lim;
      return t;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         mtgt[k] = 0; mcur[k] = 0; mw[k] = 0; men[k] = 0;
      end
   endtask

   task automatic model_boundary(input logic [1:0] en);
      for (int k = 0; k < NCH; k++) begin
         mcur[k] = stepc(mcur[k], mtgt[k]);
         mw[k]   = wfor(mcur[k]);
         men[k]  = en[k];
      end
   endtask

   task automatic wait_tick(output int n, output int hi);
      n  = 0;
      hi = 0;
      do begin
         @(negedge clk);
         n++;
         hi += int'(pwm_out[0]) + int'(pwm_out[1]);
      end while (!frame_tick && n < 300);
   endtask

   // Called on the frame-start sample; returns on the next frame-start sample.
   task automatic measure(input int load_at, input int a0, input int a1, input logic [1:0] vld,
                          input int drop_at, input logic [1:0] drop_en,
                          output int h0, output int h1, output int f0, output int l0,
                          output int tick_bad, output logic [1:0] set_mid);
      h0 = 0; h1 = 0; f0 = -1; l0 = -1; tick_bad = 0; set_mid = '0;
      for (int i = 0; i < PER; i++) begin
         if (i > 0) @(negedge clk);
         if (pwm_out[0]) begin
            h0++;
            if (f0 < 0) f0 = i;
            l0 = i;
         end
         if (pwm_out[1]) h1++;
         if (frame_tick != (i == 0)) tick_bad++;
         if (i == 50) set_mid = settled;
         if (i == load_at + 1) angle_valid = '0;
         if (i == load_at) begin
            angle_in    = {AW'(a1), AW'(a0)};
            angle_valid = vld;
         end
         if (i == drop_at) enable = drop_en;
      end
      @(negedge clk);
      angle_valid = '0;
   endtask

   task automatic run_frame(input string nm, input int load_at, input int a0, input int a1,
                            input logic [1:0] vld, input logic [1:0] en,
                            input int drop_at, input logic [1:0] drop_en,
                            output int h0, output int h1, output logic [1:0] sm);
      int         eh [NCH];
      int         tm [NCH];
      int         av [NCH];
      logic [1:0] es;
      logic [1:0] eff_en;
      int         f0, l0, tb;
      av[0] = a0;
      av[1] = a1;
      for (int k = 0; k < NCH; k++) begin
         eh[k] = men[k] ? mw[k] : 0;
         tm[k] = mtgt[k];
         if (load_at >= 0 && load_at < 49 && vld[k]) tm[k] = clampa(av[k]);
         es[k] = (mcur[k] == tm[k]);
      end
      enable = en;
      measure(load_at, a0, a1, vld, drop_at, drop_en, h0, h1, f0, l0, tb, sm);
      chk({nm, "_hi0"}, h0, eh[0]);
      chk({nm, "_hi1"}, h1, eh[1]);
      chk({nm, "_tick"}, tb, 0);
      chk({nm, "_settled"}, int'(sm), int'(es));
      if (h0 > 0) begin
         chk({nm, "_first0"}, f0, 1);
         chk({nm, "_last0"}, l0, h0);
      end
      if (load_at >= 0 && load_at < PER - 1)
         for (int k = 0; k < NCH; k++) if (vld[k]) mtgt[k] = clampa(av[k]);
      eff_en = (drop_at >= 0 && drop_at < PER - 1) ? drop_en : en;
      model_boundary(eff_en);
      if (load_at == PER - 1)
         for (int k = 0; k < NCH; k++) if (vld[k]) mtgt[k] = clampa(av[k]);
   endtask

   initial begin
      int         n, hi, h0, h1;
      logic [1:0] sm;
      vec_t       tbl [6];
      int         sx  [4];
      int         ss  [4];

      rst_n = 1'b0; angle_in = '0; angle_valid = '0; enable = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("reset_pwm", int'(pwm_out), 0);
      chk("reset_tick", int'(frame_tick), 0);
      chk("reset_settled", int'(settled), 3);
      @(negedge clk);
      rst_n = 1'b1;
      wait_tick(n, hi);
      chk("post_reset_tick_gap", n, 100);
      chk("post_reset_frame_hi", hi, 0);
      model_boundary(enable);

`ifndef SERVO_SLEW_EN
      tbl[0] = '{90,  0,   2'b01, 2'b01, 15, 0};
      tbl[1] = '{0,   210, 2'b10, 2'b11, 15, 20};
      tbl[2] = '{0,   0,   2'b01, 2'b11, 10, 20};
      tbl[3] = '{180, 45,  2'b11, 2'b10, 0,  12};
      tbl[4] = '{0,   0,   2'b00, 2'b00, 0,  0};
      tbl[5] = '{255, 1,   2'b11, 2'b11, 20, 10};
      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("tbl%0d", i), 0, tbl[i].a0, tbl[i].a1, tbl[i].vld, tbl[i].en,
                   -1, 2'b00, h0, h1, sm);
         if (i == 0) chk("first_frame_low", h0 + h1, 0);
         else begin
            chk($sformatf("tbl%0d_vec0", i), h0, tbl[i-1].x0);
            chk($sformatf("tbl%0d_vec1", i), h1, tbl[i-1].x1);
         end
      end
      run_frame("tbl_tail", -1, 0, 0, 2'b00, tbl[5].en, -1, 2'b00, h0, h1, sm);
      chk("tbl_tail_vec0", h0, tbl[5].x0);
      chk("tbl_tail_vec1", h1, tbl[5].x1);
`else
      sx[0] = 11; sx[1] = 13; sx[2] = 15; sx[3] = 15;
      ss[0] = 0;  ss[1] = 0;  ss[2] = 1;  ss[3] = 1;
      run_frame("slew_ld", 0, 90, 0, 2'b01, 2'b01, -1, 2'b00, h0, h1, sm);
      for (int j = 0; j < 4; j++) begin
         run_frame($sformatf("slew%0d", j), -1, 0, 0, 2'b00, 2'b01, -1, 2'b00, h0, h1, sm);
         chk($sformatf("slew%0d_width", j), h0, sx[j]);
         chk($sformatf("slew%0d_settled", j), int'(sm[0]), ss[j]);
      end
`endif

      // Enable drop mid-pulse: running pulse completes, next frame is dark.
      run_frame("ed_set", 0, 90, 0, 2'b01, 2'b01, -1, 2'b00, h0, h1, sm);
      repeat (6) run_frame("ed_settle", -1, 0, 0, 2'b00, 2'b01, -1, 2'b00, h0, h1, sm);
      run_frame("ed_drop", -1, 0, 0, 2'b00, 2'b01, 5, 2'b00, h0, h1, sm);
      chk("ed_drop_full_pulse", h0, 15);
      run_frame("ed_after", -1, 0, 0, 2'b00, 2'b00, -1, 2'b00, h0, h1, sm);
      chk("ed_after_dark", h0, 0);

      // Load on the boundary cycle: old target governs the next frame.
      run_frame("rc_set", 0, 0, 0, 2'b10, 2'b10, -1, 2'b00, h0, h1, sm);
      repeat (7) run_frame("rc_settle", -1, 0, 0, 2'b00, 2'b10, -1, 2'b00, h0, h1, sm);
      run_frame("rc_race", 99, 0, 180, 2'b10, 2'b10, -1, 2'b00, h0, h1, sm);
      run_frame("rc_next", -1, 0, 0, 2'b00, 2'b10, -1, 2'b00, h0, h1, sm);
      chk("rc_next_old_width", h1, 10);
      run_frame("rc_after", -1, 0, 0, 2'b00, 2'b10, -1, 2'b00, h0, h1, sm);
`ifndef SERVO_SLEW_EN
      chk("rc_after_new_width", h1, 20);
`endif

      // Asynchronous reset in the middle of a running pulse.
      run_frame("mr_set", 0, 90, 90, 2'b11, 2'b11, -1, 2'b00, h0, h1, sm);
      repeat (6) run_frame("mr_settle", -1, 0, 0, 2'b00, 2'b11, -1, 2'b00, h0, h1, sm);
      repeat (5) @(negedge clk);
      chk("mr_pre_pwm", int'(pwm_out), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_pwm", int'(pwm_out), 0);
      chk("mr_tick", int'(frame_tick), 0);
      chk("mr_settled", int'(settled), 3);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      wait_tick(n, hi);
      chk("mr_tick_gap", n, 100);
      chk("mr_first_frame_hi", hi, 0);
      model_boundary(enable);

      for (int r = 0; r < 25; r++) begin
         int         la, da, sel;
         logic [1:0] vld, en, den;
         sel = int'($urandom_range(0, 3));
         la  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 40)) : (sel == 2) ? 99 : -1;
         da  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 90)) : -1;
         vld = 2'($urandom);
         en  = 2'($urandom);
         den = 2'($urandom);
         run_frame($sformatf("rnd%0d", r), la, int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), vld, en, da, den, h0, h1, sm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/servo_pwm_array.md
Name: servo_pwm_array

Overview:
- Multi-channel hobby-servo PWM generator driving NUM_CH outputs from one shared frame counter.
- Per-channel angle targets are clamped to MAX_ANGLE and mapped linearly to pulse widths.
- Pulse widths update only at frame boundaries, so no pulse is ever glitched mid-frame.
- Sits between the control logic (switches or a command decoder) and the servo header pins.

Parameters:
- NUM_CH, 4, number of servo channels.
- PERIOD_CYCLES, 1000000, frame length in clk cycles (20 ms at 50 MHz).
- MIN_PULSE, 50000, high-time in cycles at angle 0.
- MAX_PULSE, 100000, high-time in cycles at angle MAX_ANGLE.
- ANGLE_W, 8, bit width of one angle field.
- MAX_ANGLE, 180, largest legal angle; larger requests are clamped to this value.
- SLEW_STEP, 2, maximum angle change per frame per channel (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- angle_in  in  NUM_CH*ANGLE_W  packed targets; channel k occupies bits [k*ANGLE_W +: ANGLE_W].
- angle_valid  in  NUM_CH  per-channel load strobe; loads the target on any cycle it is high.
- enable  in  NUM_CH  per-channel output enable, sampled at the frame boundary.
- pwm_out  out  NUM_CH  registered PWM outputs.
- frame_tick  out  1  one-cycle pulse marking each frame start.
- settled  out  NUM_CH  high when the current angle equals the target angle.

Behaviour:
- Reset (async assert, sync release): the following all clear to 0:
  - counter
  - all target and current angles
  - pulse-width latches and enable latches
  - pwm_out, frame_tick
  - settled resets to all-ones, because current equals target at 0.
- Frame counter: counts 0..PERIOD_CYCLES-1, then wraps to 0. Width is $clog2(PERIOD_CYCLES).
- Boundary cycle: the cycle where counter == PERIOD_CYCLES-1.
- Target load:
  - When angle_valid[k] is high, target[k] <= min(angle_in field k, MAX_ANGLE).
  - Loading may happen on any cycle. The last load before a boundary is the one that applies.
- On the boundary cycle, for each channel k:
  - next_cur is current[k] stepped toward target[k], using the target value held before this cycle.
  - current[k] <= next_cur.
  - width[k] <= MIN_PULSE + (next_cur*(MAX_PULSE-MIN_PULSE))/MAX_ANGLE.
  - en_lat[k] <= enable[k].
- Simultaneous angle_valid and boundary: the target register takes the new value, but the step uses the old target. The new target takes effect at the next boundary.
- Arithmetic:
  - Unsigned arithmetic throughout; division truncates.
  - The product is held at width ANGLE_W + $clog2(MAX_PULSE-MIN_PULSE+1), with no overflow.
  - The width register has the same width as the counter.
- Output: pwm_out[k] <= en_lat[k] && (counter < width[k]), registered.
  - pwm_out is one cycle behind the counter.
  - High time is exactly width[k] cycles per frame.
  - The low cycle count is PERIOD_CYCLES - width[k].
- frame_tick: registered, high for exactly the one cycle in which counter == 0.
- settled[k]: registered, equals (current[k] == target[k]).
- First frame after reset: en_lat is 0, so all outputs stay low. The first possible pulse comes in the frame after the first boundary.
- Disable: enable falling mid-frame does not truncate the running pulse. The output goes low starting from the next frame.
- Reset mid-frame: pwm_out drops to 0 immediately (asynchronously). Counting restarts from 0.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined:
  - Per boundary, current[k] moves toward target[k] by min(SLEW_STEP, |target-current|).
  - It never overshoots.
- Undefined:
  - current[k] <= target[k] at every boundary; settled is high again one cycle later.
  - The SLEW_STEP parameter is ignored, but remains legal.

Test Plan (all with PERIOD_CYCLES=100, MIN_PULSE=10, MAX_PULSE=20, MAX_ANGLE=180, NUM_CH=2):
- Reset check: assert rst_n low mid-frame -> pwm_out=0 and frame_tick=0 immediately; settled=2'b11; no pulse in the first frame after release.
- Angle 90 on ch0 with enable, macro off -> from the second frame on, pwm_out[0] is high for exactly 15 cycles per 100; ch1 is disabled and stays low.
- Clamp: angle 210 on ch1 -> high time 20 cycles (same as angle 180); target reads 180.
- Slew, macro on, SLEW_STEP=30, 0->90:
  - High times per frame: 11, 13, 15, 15.
  - settled[0] goes high only after the third boundary.
- Boundary race: angle_valid with 180 on the boundary cycle (previous target 0) -> the next frame still uses width 10; the frame after that uses 20 (macro off).
- Enable drop at counter=5 with width 15 -> the current pulse completes its full 15 cycles; the next frame is all low; frame_tick pulses every 100 cycles throughout.
